// File: rtl/phase_diff_decim_pkg.sv
// Shared definitions for the phase-domain blocks.
//   - state_t   : PRIME/RUN state of the differentiator.
//   - pi_q      : quantised half turn for a given fractional width and unit.
//   - two_pi_q  : exactly twice pi_q.
//   - wrap_diff : folds a raw angle difference into [-pi_q, pi_q).
package phase_diff_pkg;

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Radians: round(pi * 2^bits_low). Turns: half of 1.0 in Q(bits_low).
   function automatic longint pi_q(input int bits_low, input int is_ibniz);
      longint q;
      if (is_ibniz != 0)
         q = longint'(1) << (bits_low - 1);
      else
         q = longint'(3.14159265358979323846 * (2.0 ** bits_low));
      return q;
   endfunction

   function automatic longint two_pi_q(input int bits_low, input int is_ibniz);
      return longint'(2) * pi_q(bits_low, is_ibniz);
   endfunction

   // One fold is enough: both operands of the raw difference already lie
   // within one turn of each other.
   function automatic longint wrap_diff(input longint raw, input longint pi_val,
                                        input longint two_pi_val);
      longint d;
      if (raw >= pi_val)
         d = raw - two_pi_val;
      else if (raw < -pi_val)
         d = raw + two_pi_val;
      else
         d = raw;
      return d;
   endfunction

endpackage

// File: rtl/phase_diff_decim_if.sv
// Result-side handshake bundle of phase_diff_decim.
//   freq_o      : signed decimated frequency word (SW bits)
//   phase_o     : signed unwrapped phase at the last sample of a block (PW bits)
//   out_valid_o : freq_o/phase_o hold a result
//   out_ready_i : consumer accepts when high together with out_valid_o
//   overrun_o   : sticky, a result was dropped under backpressure
// master = producer (phase_diff_decim), slave = consumer.
// SW and PW must equal W+$clog2(DECIM)+1 and W+PHASE_EXT of the attached block.
interface phase_diff_decim_if #(
   parameter int SW = 35,
   parameter int PW = 40
);
   logic signed [SW-1:0] freq_o;
   logic signed [PW-1:0] phase_o;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic                 overrun_o;

   modport master (
      output freq_o, phase_o, out_valid_o, overrun_o,
      input  out_ready_i
   );

   modport slave (
      input  freq_o, phase_o, out_valid_o, overrun_o,
      output out_ready_i
   );
endinterface

// File: rtl/phase_diff_decim_wrap.sv
// phase_wrap_diff: differentiates the free-running angle stream.
// Holds the previous angle, the PRIME/RUN state and the first pipeline stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous restart (back to PRIME, in-flight difference dropped)
//   angle      : signed W-bit angle
//   valid      : angle valid this cycle
//   d_p1       : wrapped difference to the previous valid angle
//   d_vld_p1   : d_p1 valid, one cycle after the sample
module phase_wrap_diff
   import phase_diff_pkg::*;
#(
   parameter int     W        = 32,
   parameter longint PI_Q     = 205887,
   parameter longint TWO_PI_Q = 411774
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic signed [W-1:0] angle,
   input  logic                valid,
   output logic signed [W-1:0] d_p1,
   output logic                d_vld_p1
);

   state_t              state;
   state_t              state_nx;
   logic signed [W-1:0] prev;
   logic signed [W:0]   raw_p0;
   logic signed [W-1:0] d_p0;
   logic                take_p0;
   longint              d_full;

   // A sample taken together with clear is ignored entirely.
   always_comb begin
      state_nx = state;
      take_p0  = 1'b0;
      if (clear) begin
         state_nx = PRIME;
      end else if (valid) begin
         case (state)
            PRIME:   state_nx = RUN;
            RUN:     take_p0  = 1'b1;
            default: state_nx = PRIME;
         endcase
      end
   end

   always_comb begin
      raw_p0 = (W+1)'(angle) - (W+1)'(prev);
      d_full = wrap_diff(longint'(raw_p0), PI_Q, TWO_PI_Q);
      d_p0   = d_full[W-1:0];
   end

   // ---- stage 1 ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= PRIME;
         prev     <= '0;
         d_p1     <= '0;
         d_vld_p1 <= 1'b0;
      end else begin
         state    <= state_nx;
         d_vld_p1 <= take_p0;
         if (valid && !clear)
            prev <= angle;
         if (take_p0)
            d_p1 <= d_p0;
      end
   end

endmodule

// File: rtl/phase_diff_decim.sv
// phase_diff_decim: FM discriminator behind the atan2 stage.
// Differentiates the angle stream, sums DECIM wrapped differences into one
// frequency word and tracks an unwrapped phase; results leave through a
// valid/ready register that drops (and flags) results it cannot hold.
// Optional feature: define PHASE_DIFF_UNWRAP_EN to build the unwrapped phase
// accumulator; without it phase_o is tied to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   angle_i    : signed angle, BITS_HIGH+BITS_LOW bits
//   valid_i    : angle_i valid (no backpressure on this side)
//   clear_i    : synchronous restart of history, counters and sticky flag
//   result     : phase_diff_decim_if master (freq_o, phase_o, out_valid_o,
//                out_ready_i, overrun_o)
module phase_diff_decim
   import phase_diff_pkg::*;
#(
   parameter int BITS_HIGH = 16,
   parameter int BITS_LOW  = 16,
   parameter int IS_IBNIZ  = 0,
   parameter int DECIM     = 4,
   parameter int PHASE_EXT = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic signed [BITS_HIGH+BITS_LOW-1:0] angle_i,
   input  logic                                valid_i,
   input  logic                                clear_i,
   phase_diff_decim_if.master                  result
);

   localparam int     W        = BITS_HIGH + BITS_LOW;
   localparam int     SW       = W + $clog2(DECIM) + 1;
   localparam int     PW       = W + PHASE_EXT;
   localparam int     CNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam longint PI_Q     = pi_q(BITS_LOW, IS_IBNIZ);
   localparam longint TWO_PI_Q = two_pi_q(BITS_LOW, IS_IBNIZ);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

   logic signed [W-1:0]  d_p1;
   logic                 d_vld_p1;
   logic signed [SW-1:0] sum_p2;
   logic [CNT_W-1:0]     cnt_p2;
   logic signed [SW-1:0] res_freq_p1;
   logic                 res_vld_p1;
   logic                 load_p1;
   logic signed [SW-1:0] freq_q;
   logic                 out_valid_q;
   logic                 overrun_q;

   phase_wrap_diff #(
      .W        (W),
      .PI_Q     (PI_Q),
      .TWO_PI_Q (TWO_PI_Q)
   ) u_wrap (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear_i),
      .angle    (angle_i),
      .valid    (valid_i),
      .d_p1     (d_p1),
      .d_vld_p1 (d_vld_p1)
   );

   // The block result includes the current difference, so it is formed
   // combinationally and lands straight in the output register.
   assign res_vld_p1  = d_vld_p1 && (cnt_p2 == CNT_LAST);
   assign res_freq_p1 = sum_p2 + SW'(d_p1);
   // Accept-and-reload: a full register being drained this cycle may reload.
   assign load_p1     = res_vld_p1 && (!out_valid_q || result.out_ready_i);

   // ---- stage 2 / output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_p2      <= '0;
         cnt_p2      <= '0;
         freq_q      <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (clear_i) begin
         sum_p2      <= '0;
         cnt_p2      <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (d_vld_p1) begin
            if (cnt_p2 == CNT_LAST) begin
               sum_p2 <= '0;
               cnt_p2 <= '0;
            end else begin
               sum_p2 <= res_freq_p1;
               cnt_p2 <= cnt_p2 + CNT_W'(1);
            end
         end
         if (out_valid_q && result.out_ready_i)
            out_valid_q <= 1'b0;
         if (load_p1) begin
            out_valid_q <= 1'b1;
            freq_q      <= res_freq_p1;
         end else if (res_vld_p1) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign result.freq_o      = freq_q;
   assign result.out_valid_o = out_valid_q;
   assign result.overrun_o   = overrun_q;

`ifdef PHASE_DIFF_UNWRAP_EN
   logic signed [PW-1:0] phase_acc_p2;
   logic signed [PW-1:0] phase_nx_p1;
   logic signed [PW-1:0] phase_q;

   // Plain modulo-2^PW wrap-around is the intended unwrapped-phase behaviour.
   assign phase_nx_p1 = phase_acc_p2 + PW'(d_p1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_acc_p2 <= '0;
         phase_q      <= '0;
      end else if (clear_i) begin
         phase_acc_p2 <= '0;
      end else begin
         if (d_vld_p1)
            phase_acc_p2 <= phase_nx_p1;
         if (load_p1)
            phase_q <= phase_nx_p1;
      end
   end

   assign result.phase_o = phase_q;
`else
   assign result.phase_o = PW'(0);
`endif

endmodule

// File: tb/tb_phase_diff_decim.sv
// Scoreboard bench for phase_diff_decim: three instances (DECIM=1, DECIM=4,
// and a narrow DECIM=1 build for accumulator wrap-around).
module tb_phase_diff_decim;

   typedef struct {
      longint f;
      longint p;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic signed [31:0] a1, a4;
   logic signed [11:0] a_s;
   logic v1, v4, vs, c1, c4, cs;

   exp_t q1[$];
   exp_t q4[$];
   exp_t qs[$];

   phase_diff_decim_if #(.SW(33), .PW(40)) r1 ();
   phase_diff_decim_if #(.SW(35), .PW(40)) r4 ();
   phase_diff_decim_if #(.SW(13), .PW(14)) rs ();

   phase_diff_decim #(.DECIM(1)) u1 (
      .clk(clk), .rst_n(rst_n), .angle_i(a1), .valid_i(v1), .clear_i(c1),
      .result(r1.master));
   phase_diff_decim #(.DECIM(4)) u4 (
      .clk(clk), .rst_n(rst_n), .angle_i(a4), .valid_i(v4), .clear_i(c4),
      .result(r4.master));
   phase_diff_decim #(.BITS_HIGH(4), .BITS_LOW(8), .DECIM(1), .PHASE_EXT(2)) us (
      .clk(clk), .rst_n(rst_n), .angle_i(a_s), .valid_i(vs), .clear_i(cs),
      .result(rs.master));

   function automatic longint ph(input longint v);
`ifdef PHASE_DIFF_UNWRAP_EN
      return v;
`else
      return 0;
`endif
   endfunction

   function automatic exp_t mk(input longint f, input longint p);
      exp_t e;
      e.f = f;
      e.p = p;
      return e;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic score(input string tag, input bit has, input exp_t e,
                        input longint f, input longint p);
      if (!has) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_unexpected: got freq=%0d phase=%0d, required no output", tag, f, p);
      end else begin
         check({tag, "_freq"}, f, e.f);
         check({tag, "_phase"}, p, e.p);
      end
   endtask

   // Monitors: pop one expectation per accepted result.
   always @(negedge clk) begin
      exp_t e;
      bit   has;
      if (rst_n && r1.out_valid_o && r1.out_ready_i) begin
         e = mk(0, 0);
         has = (q1.size() != 0);
         if (has) e = q1.pop_front();
         score("u1", has, e, longint'(r1.freq_o), longint'(r1.phase_o));
      end
   end

   always @(negedge clk) begin
      exp_t e;
      bit   has;
      if (rst_n && r4.out_valid_o && r4.out_ready_i) begin
         e = mk(0, 0);
         has = (q4.size() != 0);
         if (has) e = q4.pop_front();
         score("u4", has, e, longint'(r4.freq_o), longint'(r4.phase_o));
      end
   end

   always @(negedge clk) begin
      exp_t e;
      bit   has;
      if (rst_n && rs.out_valid_o && rs.out_ready_i) begin
         e = mk(0, 0);
         has = (qs.size() != 0);
         if (has) e = qs.pop_front();
         score("us", has, e, longint'(rs.freq_o), longint'(rs.phase_o));
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic s1(input longint ang);
      a1 = 32'(ang); v1 = 1'b1;
      @(posedge clk); #1;
      v1 = 1'b0;
   endtask

   task automatic s4(input longint ang);
      a4 = 32'(ang); v4 = 1'b1;
      @(posedge clk); #1;
      v4 = 1'b0;
   endtask

   task automatic ss(input longint ang);
      a_s = 12'(ang); vs = 1'b1;
      @(posedge clk); #1;
      vs = 1'b0;
   endtask

   task automatic clr1();
      c1 = 1'b1;
      @(posedge clk); #1;
      c1 = 1'b0;
   endtask

   // Clear with a simultaneous sample that must be ignored.
   task automatic clr4v(input longint ang);
      c4 = 1'b1; v4 = 1'b1; a4 = 32'(ang);
      @(posedge clk); #1;
      c4 = 1'b0; v4 = 1'b0;
   endtask

   initial begin
      longint ang;
      longint ph_m;
      a1 = '0; a4 = '0; a_s = '0;
      v1 = 1'b0; v4 = 1'b0; vs = 1'b0;
      c1 = 1'b0; c4 = 1'b0; cs = 1'b0;
      r1.out_ready_i = 1'b1;
      r4.out_ready_i = 1'b1;
      rs.out_ready_i = 1'b1;
      idle(2);

      // Reset state
      check("rst_valid", longint'(r1.out_valid_o), 0);
      check("rst_freq", longint'(r1.freq_o), 0);
      check("rst_phase", longint'(r1.phase_o), 0);
      check("rst_overrun", longint'(r1.overrun_o), 0);
      check("rst_valid4", longint'(r4.out_valid_o), 0);
      rst_n = 1'b1;
      idle(1);

      // Basic differences, first sample only primes
      q1.push_back(mk(1000, ph(1000)));
      q1.push_back(mk(2000, ph(3000)));
      s1(0); s1(1000); s1(3000);
      idle(3);

      // Wrap in both directions
      clr1();
      q1.push_back(mk(11774, ph(11774)));
      s1(200000); s1(-200000);
      idle(3);
      clr1();
      q1.push_back(mk(-11774, ph(-11774)));
      s1(-200000); s1(200000);
      idle(3);

      // Constant +150000 steps through angle wraps: phase keeps growing
      clr1();
      q1.push_back(mk(150000, ph(150000)));
      q1.push_back(mk(150000, ph(300000)));
      q1.push_back(mk(150000, ph(450000)));
      s1(0); s1(150000); s1(-111774); s1(38226);
      idle(3);

      // Backpressure: first result held, later two dropped
      clr1();
      r1.out_ready_i = 1'b0;
      q1.push_back(mk(100, ph(100)));
      s1(0); s1(100); s1(300); s1(600);
      idle(3);
      check("bp_valid", longint'(r1.out_valid_o), 1);
      check("bp_freq", longint'(r1.freq_o), 100);
      check("bp_overrun", longint'(r1.overrun_o), 1);
      idle(2);
      check("bp_freq_held", longint'(r1.freq_o), 100);
      check("bp_phase_held", longint'(r1.phase_o), ph(100));
      r1.out_ready_i = 1'b1;
      idle(1);
      check("bp_valid_drop", longint'(r1.out_valid_o), 0);
      idle(2);
      check("bp_overrun_sticky", longint'(r1.overrun_o), 1);
      clr1();
      check("bp_overrun_clear", longint'(r1.overrun_o), 0);

      // DECIM=4: latency and two blocks
      q4.push_back(mk(20000, ph(20000)));
      q4.push_back(mk(20000, ph(40000)));
      for (int k = 0; k < 5; k++) s4(k * 5000);
      check("u4_lat_early", longint'(r4.out_valid_o), 0);
      idle(1);
      check("u4_lat_2cyc", longint'(r4.out_valid_o), 1);
      for (int k = 5; k < 9; k++) s4(k * 5000);
      idle(3);

      // Clear after 2 of 4 differences; sample with clear is ignored
      clr4v(0);
      s4(0); s4(1000); s4(2000);
      clr4v(99999);
      idle(4);
      check("u4_partial_none", longint'(r4.out_valid_o), 0);
      q4.push_back(mk(40, ph(40)));
      s4(50000); s4(50010); s4(50020); s4(50030); s4(50040);
      idle(3);

      // Narrow build: +PI_Q/2 ramp wraps the phase accumulator (2^13)
      ang = 0;
      ph_m = 0;
      ss(0);
      for (int k = 0; k < 24; k++) begin
         ang = ang + 402;
         if (ang >= 804) ang = ang - 1608;
         ph_m = ph_m + 402;
         if (ph_m >= 8192) ph_m = ph_m - 16384;
         qs.push_back(mk(402, ph(ph_m)));
         ss(ang);
      end
      idle(3);

      // Asynchronous reset between edges while a result is held
      r1.out_ready_i = 1'b0;
      clr1();
      s1(0); s1(7);
      idle(3);
      check("ar_pre_valid", longint'(r1.out_valid_o), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", longint'(r1.out_valid_o), 0);
      check("ar_freq", longint'(r1.freq_o), 0);
      check("ar_phase", longint'(r1.phase_o), 0);
      check("ar_overrun", longint'(r1.overrun_o), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      r1.out_ready_i = 1'b1;
      idle(1);
      q1.push_back(mk(5, ph(5)));
      s1(10); s1(15);
      idle(3);

      check("q1_drained", longint'(q1.size()), 0);
      check("q4_drained", longint'(q4.size()), 0);
      check("qs_drained", longint'(qs.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
